capture_buffer: RTL and testbench

- Response-side counterpart to the file-driven stimulus path: captures the N-bit q/qbar pair of a unit under test into an on-chip buffer during a capture window.
- Checks that qbar is the bitwise complement of q on every captured sample.
- Drains the stored records in order over a valid/ready port to a downstream consumer (UART bridge or bench monitor), which emits them as "q,qbar" lines.

---
 rtl/capture_buffer.sv | 117 +++++++++++
 tb/tb_capture_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// Captures q/qbar sample pairs during a start/stop window, counts complement violations, then drains records in order.
// Latency: a sample is stored on the edge where in_valid is seen; out_data is read straight from storage (zero cycles).
// Backpressure: out_data/out_valid are held while out_ready is low; samples arriving on a full buffer are dropped and flagged.
module capture_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [N-1:0]     q,
  input  logic [N-1:0]     qbar,
  output logic [2*N-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      mismatch_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t               state;
  state_t               state_nx;
  logic [2*N-1:0]       mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 sample;
  logic                 wr_en;
  logic                 pop;
  logic                 bad;

  // Per-cycle qualifiers derived from state and inputs.
  always_comb begin
    full   = (count == FULL_CNT);
    sample = (state == S_CAPTURE) && in_valid;
    wr_en  = sample && !full;
    bad    = (q != ~qbar);
    pop    = out_valid && out_ready;
  end

  assign out_valid = (state == S_DRAIN) && (count != '0);
  assign out_data  = mem[rd_ptr];
  assign busy      = (state == S_CAPTURE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  // State register; reset abandons any window in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: window open/close, drain until empty, one-cycle DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_CAPTURE;
      S_CAPTURE: if (stop)  state_nx = S_DRAIN;
      S_DRAIN:   if ((count == '0) || (pop && (count == (AW+1)'(1)))) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Pointers, occupancy and status flags; writes and pops never coincide (different states).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        overflow     <= 1'b0;
        mismatch_cnt <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
      if (sample && full) begin
        overflow <= 1'b1;
      end
      if (sample && bad && (mismatch_cnt != 16'hFFFF)) begin
        mismatch_cnt <= mismatch_cnt + 16'd1;
      end
    end
  end

  // Record storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {q, qbar};
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
module tb_capture_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  q = '0;
  logic [7:0]  qbar = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  count;
  logic        busy;
  logic        overflow;
  logic [15:0] mismatch_cnt;
  logic        done;

  capture_buffer #(.N(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid),
    .q(q), .qbar(qbar), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .busy(busy), .overflow(overflow), .mismatch_cnt(mismatch_cnt), .done(done)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a record list plus window statistics.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          exp_mis;
  bit          exp_ovf;
  int          done_cnt;
  int          done_iter;
  bit          timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sample(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] nb;
    nb = ~b;
    if (a != nb && exp_mis < 65535) exp_mis++;
    if (exp_q.size() < 16) exp_q.push_back({a, b});
    else exp_ovf = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_mis = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic do_sample(input logic [7:0] a, input logic [7:0] b, input bit with_stop);
    in_valid = 1'b1; q = a; qbar = b; stop = with_stop;
    tick();
    in_valid = 1'b0; stop = 1'b0;
    model_sample(a, b);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Consume records with a random ready pattern until done has been seen (bounded).
  task automatic drain_all(input int ready_pct);
    got_q.delete();
    done_cnt = 0; done_iter = -1; timeout = 1'b0;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) begin
        done_cnt++;
        if (done_iter < 0) done_iter = i;
      end
      tick();
      if (done_iter >= 0 && i >= done_iter + 3) break;
    end
    out_ready = 1'b0;
    if (done_iter < 0) timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags valid=%b busy=%b done=%b exp=000", out_valid, busy, done); end
    checks++; if (overflow !== 1'b0 || mismatch_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_status ovf=%b mis=%0d exp=0/0", overflow, mismatch_cnt); end
  endtask

  task automatic test_basic();
    do_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    do_sample(8'h0F, 8'hF0, 1'b0);
    do_sample(8'hA5, 8'h5A, 1'b0);
    do_sample(8'h00, 8'hFF, 1'b0);
    do_stop();
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
    drain_all(100);
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_size got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); end
    end
    checks++; if (timeout || done_iter != 3 || done_cnt != 1) begin
      errors++; $display("FAIL basic_done iter=%0d cnt=%0d exp iter=3 cnt=1", done_iter, done_cnt); end
    checks++; if (count !== 5'd0 || mismatch_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL basic_end count=%0d mis=%0d ovf=%b exp=0/0/0", count, mismatch_cnt, overflow); end
    exp_q.delete();
  endtask

  task automatic test_complement();
    do_start();
    do_sample(8'h12, 8'hED, 1'b0);
    do_sample(8'h12, 8'h12, 1'b0);
    do_sample(8'hFF, 8'h01, 1'b0);
    do_stop();
    drain_all(100);
    checks++; if (mismatch_cnt !== 16'd2 || exp_mis != 2) begin
      errors++; $display("FAIL compl_mis got=%0d exp=2", mismatch_cnt); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL compl_size got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL compl_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    do_start();
    for (int i = 0; i < 20; i++) begin
      v = 8'(i);
      do_sample(v, ~v, 1'b0);
    end
    checks++; if (count !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full count=%0d ovf=%b exp=16/1", count, overflow); end
    do_stop();
    drain_all(100);
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL ovf_size got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      v = 8'(i);
      checks++;
      if (i >= got_q.size() || got_q[i] !== {v, ~v}) begin
        errors++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, {v, ~v}); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    exp_q.delete();
    do_start();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    do_stop();
    drain_all(100);
    checks++; if (got_q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL ovf_empty size=%0d done=%0d exp=0/1", got_q.size(), done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    do_start();
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom);
      do_sample(a, ~a, 1'b0);
    end
    do_stop();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0] || count !== 5'd2) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b data=%h count=%0d exp=1/%h/2", i, out_valid, out_data, count, exp_q[0]); end
      tick();
    end
    drain_all(100);
    checks++; if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL bp_data size=%0d exp=2 first=%h/%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx, exp_q[0]); end
    checks++; if (done_iter != 2 || done_cnt != 1) begin
      errors++; $display("FAIL bp_done iter=%0d cnt=%0d exp=2/1", done_iter, done_cnt); end
    exp_q.delete();
  endtask

  task automatic test_boundary();
    logic [7:0] a;
    in_valid = 1'b1; q = 8'h33; qbar = 8'hCC;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 5'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL bnd_idle count=%0d busy=%b exp=0/0", count, busy); end
    do_start();
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      do_sample(a, ~a, 1'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count !== 5'd3 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bnd_start_cap count=%0d busy=%b valid=%b exp=3/1/0", count, busy, out_valid); end
    a = 8'($urandom);
    do_sample(a, ~a, 1'b1);
    checks++; if (count !== 5'd4 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bnd_stop_sample count=%0d valid=%b exp=4/1", count, out_valid); end
    start = 1'b1; stop = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 5'd4 || busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bnd_drain_ign count=%0d busy=%b valid=%b exp=4/1/1", count, busy, out_valid); end
    drain_all(100);
    checks++; if (got_q.size() != 4 || done_cnt != 1) begin
      errors++; $display("FAIL bnd_drain size=%0d done=%0d exp=4/1", got_q.size(), done_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bnd_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); end
    end
    exp_q.delete();
    do_start();
    do_stop();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL bnd_empty_drain valid=%b busy=%b done=%b exp=0/1/0", out_valid, busy, done); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bnd_empty_done done=%b busy=%b exp=1/0", done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL bnd_done_pulse done=%b exp=0", done); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    do_start();
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom);
      do_sample(a, ~a, 1'b0);
    end
    do_stop();
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL rmid_pre count=%0d exp=3", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    checks++; if (count !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmid_state count=%0d valid=%b busy=%b done=%b exp=0/0/0/0", count, out_valid, busy, done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_nodone done=%b busy=%b exp=0/0", done, busy); end
    do_start();
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom);
      do_sample(a, ~a, 1'b0);
    end
    do_stop();
    drain_all(100);
    checks++; if (got_q.size() != 2 || done_cnt != 1) begin
      errors++; $display("FAIL rmid_size size=%0d done=%0d exp=2/1", got_q.size(), done_cnt); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rmid_data[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int n;
    int stored;
    logic [7:0] a;
    logic [7:0] b;
    for (int w = 0; w < 6; w++) begin
      n = $urandom_range(20);
      do_start();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(9) < 3) tick();
        a = 8'($urandom);
        b = ($urandom_range(3) == 0) ? 8'($urandom) : ~a;
        do_sample(a, b, 1'b0);
      end
      do_stop();
      stored = (n < 16) ? n : 16;
      checks++; if (count !== 5'(stored) || overflow !== exp_ovf) begin
        errors++; $display("FAIL rnd%0d_fill count=%0d ovf=%b exp=%0d/%b", w, count, overflow, stored, exp_ovf); end
      drain_all(50);
      checks++; if (timeout || done_cnt != 1 || got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_drain size=%0d done=%0d exp=%0d/1", w, got_q.size(), done_cnt, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", w, i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); end
      end
      checks++; if (mismatch_cnt !== 16'(exp_mis)) begin
        errors++; $display("FAIL rnd%0d_mis got=%0d exp=%0d", w, mismatch_cnt, exp_mis); end
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_mis = 0;
    exp_ovf = 1'b0;
    test_reset();
    test_basic();
    test_complement();
    test_overflow();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
